// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract controller.
package serial_add_pkg;

    localparam int SA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requesting FSM (master) and serial_add_ctrl (slave).
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
);

    // start is sampled only while the controller is idle (busy=0, done=0); a start at any
    // other time is dropped. busy stays high while bits are processed, and done pulses for
    // one cycle with sum/c_out/ovf valid. The results hold until the next completion.
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    sa_state_e        dbg_state;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, sum, c_out, ovf, dbg_state
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, sum, c_out, ovf, dbg_state
    );

endinterface

// File: rtl/serial_add_ctrl_adder.sv
// The team's 1-bit full adder; the only combinational arithmetic in the serial adder.
module adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic o,
    output logic c_out
);

    assign o     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one bit per clock, LSB first, carry held in a flop between bits.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic             fa_o;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;

    adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .o     (fa_o),
        .c_out (fa_c)
    );

    // The newest bit lands in the MSB; after WIDTH shifts the first bit sits at bit 0.
    // Only WIDTH-1 bits need storing because the final bit comes straight from the adder.
    assign res_next = {fa_o, res_sh_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ADD;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.c_in;
                    cnt_d   = '0;
                end
            end
            ADD: begin
                res_sh_d = res_next[WIDTH-1:1];
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_c;
                if (cnt_q == CNT_LAST) begin
                    // Counter holds at its terminal value so it never wraps.
                    state_d = DONE;
                    sum_d   = res_next;
                    c_out_d = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy      = (state_q == ADD);
    assign bus.done      = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed scoreboard bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [W+1:0] exp_q[$];

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands, packed as {c_out, ovf, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        int ua, ub, sa, sb, ur, sr;
        logic c, v;
        logic [W-1:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            c  = (ur >= (1 << W));
        end
        s = ur[W-1:0];
        v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        return {c, v, s};
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        logic prev_done;
        logic [W+1:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                check("done_single_pulse", {31'd0, prev_done}, 32'd0);
                check("busy_low_in_done", {31'd0, bus.busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {22'd0, bus.c_out, bus.ovf, bus.sum}, {22'd0, e});
                end
            end
            prev_done = rst_n && bus.done;
        end
    end

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
        bus.sub   = sub;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom_range(0, (1 << W) - 1));
        bus.b     = W'($urandom_range(0, (1 << W) - 1));
        bus.c_in  = 1'($urandom_range(0, 1));
        bus.sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'(W));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        int lat;
        exp_q.push_back(model(a, b, cin, sub));
        drive_start(a, b, cin, sub);
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        wait_done(lat);
        @(posedge clk);
    endtask

    initial begin
        int lat;
        logic [W+1:0] held;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;

        // Reset asserted together with start: reset must win.
        repeat (1) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", {24'd0, bus.sum}, 32'd0);
        check("rst_c_out", {31'd0, bus.c_out}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(8'h3C, 8'h5A, 1'b0, 1'b0);
        do_op(8'h10, 8'h20, 1'b1, 1'b0);
        held = model(8'h10, 8'h20, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("result_held", {22'd0, bus.c_out, bus.ovf, bus.sum}, {22'd0, held});
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h05, 8'h07, 1'b0, 1'b1);
        do_op(8'h80, 8'h01, 1'b0, 1'b1);
        do_op(8'h05, 8'h07, 1'b1, 1'b1);

        // Extra start pulses during ADD must be ignored.
        exp_q.push_back(model(8'h21, 8'h43, 1'b0, 1'b0));
        drive_start(8'h21, 8'h43, 1'b0, 1'b0);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (k == 3 || k == W) begin
                bus.start = 1'b1;
                bus.a     = 8'hF0;
                bus.b     = 8'h0F;
                bus.sub   = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
        end
        #1;
        bus.start = 1'b0;
        check("ignored_start_done", {31'd0, bus.done}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("ignored_start_idle", {31'd0, bus.busy}, 32'd0);
        end

        // Reset in the middle of ADD discards the operation.
        drive_start(8'h77, 8'h66, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_sum", {24'd0, bus.sum}, 32'd0);
        rst_n = 1'b1;
        repeat (W + 3) @(posedge clk);
        do_op(8'h01, 8'h02, 1'b0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        lat = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
